// File: rtl/debounce_scan_if.sv
// Event handshake between the debounce scheduler and its consumer.
// The master holds chan/level stable while valid until ready is seen.
interface debounce_scan_if #(
    parameter int CW = 3
);
    logic          evt_valid;
    logic [CW-1:0] evt_chan;
    logic          evt_level;
    logic          evt_ready;

    modport master (
        output evt_valid,
        output evt_chan,
        output evt_level,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_chan,
        input  evt_level,
        output evt_ready
    );
endinterface

// File: rtl/debounce_scan.sv
// Time-multiplexed debouncer: one count engine visits each channel in
// turn on a prescaled tick and reports committed level changes as events.
module debounce_scan #(
    parameter int CHANNELS  = 8,
    parameter int MAX_COUNT = 16,
    parameter int TICK_DIV  = 1000
) (
    input  logic                clock,
    input  logic                i_nrst,
    input  logic [CHANNELS-1:0] i_in,
    output logic [CHANNELS-1:0] o_state,
    output logic                o_overflow,
    input  logic                i_ovf_clr,
    debounce_scan_if.master     evt
);
    localparam int CW = $clog2(CHANNELS);
    localparam int NW = $clog2(MAX_COUNT);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0] PTR_LAST = CW'(CHANNELS - 1);
    localparam logic [NW-1:0] CNT_LAST = NW'(MAX_COUNT - 1);

    logic [PW-1:0] pre;
    logic [CW-1:0] ptr;
    logic [NW-1:0] cnt [CHANNELS];

    logic tick;
    logic cur_in;
    logic cur_st;
    logic differ;
    logic commit;
    logic busy;

    assign tick   = (pre == PRE_LAST);
    assign cur_in = i_in[ptr];
    assign cur_st = o_state[ptr];
    assign differ = tick && (cur_in != cur_st);
    assign commit = differ && (cnt[ptr] == CNT_LAST);
    // A held event not being taken this cycle blocks a new one.
    assign busy   = evt.evt_valid && !evt.evt_ready;

    always_ff @(posedge clock or negedge i_nrst) begin
        if (!i_nrst) begin
            pre <= '0;
            ptr <= '0;
        end else begin
            pre <= tick ? '0 : pre + 1'b1;
            if (tick)
                ptr <= (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge i_nrst) begin
        if (!i_nrst) begin
            for (int n = 0; n < CHANNELS; n++)
                cnt[n] <= '0;
        end else if (tick) begin
            if (!differ || commit)
                cnt[ptr] <= '0;
            else
                cnt[ptr] <= cnt[ptr] + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge i_nrst) begin
        if (!i_nrst)
            o_state <= '0;
        else if (commit)
            o_state[ptr] <= cur_in;
    end

    always_ff @(posedge clock or negedge i_nrst) begin
        if (!i_nrst) begin
            evt.evt_valid <= 1'b0;
            evt.evt_chan  <= '0;
            evt.evt_level <= 1'b0;
        end else if (commit && !busy) begin
            evt.evt_valid <= 1'b1;
            evt.evt_chan  <= ptr;
            evt.evt_level <= cur_in;
        end else if (evt.evt_ready) begin
            evt.evt_valid <= 1'b0;
        end
    end

    // A drop in the same cycle as a clear leaves the flag set.
    always_ff @(posedge clock or negedge i_nrst) begin
        if (!i_nrst)
            o_overflow <= 1'b0;
        else if (commit && busy)
            o_overflow <= 1'b1;
        else if (i_ovf_clr)
            o_overflow <= 1'b0;
    end
endmodule

// File: tb/tb_debounce_scan.sv
// Scoreboard bench for debounce_scan with 4 channels, 4 visits, tick/2.
// Expected events are queued at stimulus time and popped on transfer.
module tb_debounce_scan;
    localparam int CH = 4;
    localparam int MC = 4;
    localparam int TD = 2;

    logic          clock = 1'b0;
    logic          i_nrst = 1'b0;
    logic [CH-1:0] in_r = '0;
    logic [CH-1:0] state;
    logic          ovf;
    logic          ovf_clr = 1'b0;

    debounce_scan_if #(.CW(2)) ev ();

    debounce_scan #(
        .CHANNELS (CH),
        .MAX_COUNT(MC),
        .TICK_DIV (TD)
    ) dut (
        .clock     (clock),
        .i_nrst    (i_nrst),
        .i_in      (in_r),
        .o_state   (state),
        .o_overflow(ovf),
        .i_ovf_clr (ovf_clr),
        .evt       (ev)
    );

    always #5 clock = ~clock;

    typedef struct {
        int chan;
        int level;
        int cyc;
    } ev_t;

    ev_t exp_q[$];
    ev_t e;
    int  total = 0;
    int  bad = 0;
    int  cyc;
    int  seen;
    bit  prev_valid;
    bit  prev_xfer;
    int  hold_chan;
    int  hold_lvl;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // cyc is 0 at the first posedge after reset release
    always @(posedge clock or negedge i_nrst) begin
        if (!i_nrst)
            cyc <= -1;
        else
            cyc <= cyc + 1;
    end

    always @(negedge clock) begin
        if (i_nrst) begin
            if (ev.evt_valid && prev_valid && !prev_xfer) begin
                chk("hold_chan", 32'(ev.evt_chan), hold_chan);
                chk("hold_lvl", 32'(ev.evt_level), hold_lvl);
            end
            if (ev.evt_valid && !(prev_valid && !prev_xfer))
                seen = cyc;
            if (ev.evt_valid && ev.evt_ready) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_evt", 32'(ev.evt_chan), 99);
                end else begin
                    e = exp_q.pop_front();
                    chk("evt_chan", 32'(ev.evt_chan), e.chan);
                    chk("evt_lvl", 32'(ev.evt_level), e.level);
                    chk("evt_cyc", seen, e.cyc);
                end
            end
            prev_valid = ev.evt_valid;
            prev_xfer  = ev.evt_valid && ev.evt_ready;
            hold_chan  = 32'(ev.evt_chan);
            hold_lvl   = 32'(ev.evt_level);
        end else begin
            prev_valid = 1'b0;
            prev_xfer  = 1'b0;
        end
    end

    task automatic at(input int n);
        while (cyc < n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic start(input logic [CH-1:0] inv, input logic rdy);
        i_nrst = 1'b0;
        exp_q.delete();
        in_r = inv;
        ev.evt_ready = rdy;
        ovf_clr = 1'b0;
        @(negedge clock);
        chk("rst_state", 32'(state), 0);
        chk("rst_valid", 32'(ev.evt_valid), 0);
        chk("rst_chan", 32'(ev.evt_chan), 0);
        chk("rst_lvl", 32'(ev.evt_level), 0);
        chk("rst_ovf", 32'(ovf), 0);
        @(negedge clock);
        i_nrst = 1'b1;
    endtask

    task automatic push(input int c, input int l, input int v);
        exp_q.push_back('{chan: c, level: l, cyc: v});
    endtask

    task automatic drain(input int n);
        at(n);
        chk("drain", exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        ev.evt_ready = 1'b0;

        // clean press on ch2: visits 5,13,21,29
        start(4'b0100, 1'b1);
        push(2, 1, 29);
        at(28);
        chk("press_pre", 32'(state), 4'b0000);
        at(29);
        chk("press_state", 32'(state), 4'b0100);
        chk("press_valid", 32'(ev.evt_valid), 1);
        at(30);
        chk("press_done", 32'(ev.evt_valid), 0);
        drain(34);

        // bounce on ch1: miss at visit 27 restarts the count
        start(4'b0010, 1'b1);
        push(1, 1, 59);
        at(19);
        in_r[1] = 1'b0;
        at(27);
        in_r[1] = 1'b1;
        at(58);
        chk("bounce_pre", 32'(state), 4'b0000);
        at(59);
        chk("bounce_state", 32'(state), 4'b0010);
        drain(64);

        // backpressure: ch1 commit is dropped behind held ch0 event
        start(4'b0011, 1'b0);
        push(0, 1, 25);
        at(26);
        chk("bp_ovf_pre", 32'(ovf), 0);
        chk("bp_state_pre", 32'(state), 4'b0001);
        at(27);
        chk("bp_valid", 32'(ev.evt_valid), 1);
        chk("bp_chan", 32'(ev.evt_chan), 0);
        chk("bp_lvl", 32'(ev.evt_level), 1);
        chk("bp_state", 32'(state), 4'b0011);
        chk("bp_ovf", 32'(ovf), 1);
        at(30);
        ev.evt_ready = 1'b1;
        at(31);
        ev.evt_ready = 1'b0;
        chk("bp_valid_drop", 32'(ev.evt_valid), 0);
        chk("bp_ovf_sticky", 32'(ovf), 1);
        ovf_clr = 1'b1;
        at(32);
        ovf_clr = 1'b0;
        chk("bp_ovf_clr", 32'(ovf), 0);
        drain(34);

        // transfer and new commit in the same cycle
        start(4'b0011, 1'b0);
        push(0, 1, 25);
        push(1, 1, 27);
        at(26);
        ev.evt_ready = 1'b1;
        at(27);
        chk("sim_valid", 32'(ev.evt_valid), 1);
        chk("sim_chan", 32'(ev.evt_chan), 1);
        chk("sim_ovf", 32'(ovf), 0);
        drain(32);

        // release after a committed press on ch3
        start(4'b1000, 1'b1);
        push(3, 1, 31);
        at(31);
        in_r[3] = 1'b0;
        push(3, 0, 63);
        at(62);
        chk("rel_pre", 32'(state), 4'b1000);
        at(63);
        chk("rel_state", 32'(state), 4'b0000);
        drain(68);

        // async reset with cnt[2]=2 and ch0 event pending
        start(4'b0001, 1'b0);
        at(5);
        in_r[2] = 1'b1;
        at(26);
        chk("ar_pend", 32'(ev.evt_valid), 1);
        i_nrst = 1'b0;
        #1;
        chk("ar_state", 32'(state), 0);
        chk("ar_valid", 32'(ev.evt_valid), 0);
        chk("ar_chan", 32'(ev.evt_chan), 0);
        chk("ar_lvl", 32'(ev.evt_level), 0);
        chk("ar_ovf", 32'(ovf), 0);
        start(4'b0101, 1'b1);
        push(0, 1, 25);
        push(2, 1, 29);
        at(28);
        chk("ar_again_pre", 32'(state), 4'b0001);
        at(29);
        chk("ar_again", 32'(state), 4'b0101);
        drain(34);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
